// File: rtl/cam_pkg.sv
// Shared defaults, derived widths and state encoding for the camera pixel unpacker.
package cam_pkg;
  localparam int BUS_WIDTH    = 96;
  localparam int PIX_WIDTH    = 24;
  localparam int SHAPE_W      = 848;
  localparam int SHAPE_H      = 480;
  localparam int PIX_PER_WORD = BUS_WIDTH / PIX_WIDTH;
  localparam int X_W          = $clog2(SHAPE_W);
  localparam int Y_W          = $clog2(SHAPE_H);

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } cam_state_e;
endpackage

// File: rtl/cam_pixel_unpacker_coord.sv
// x/y raster counters for the unpacked pixel stream, with sof/eol/eof decode.
module cam_pixel_coord #(
  parameter int SHAPE_W = cam_pkg::SHAPE_W,
  parameter int SHAPE_H = cam_pkg::SHAPE_H
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       adv,
  input  logic                       clr,
  output logic [$clog2(SHAPE_W)-1:0] x,
  output logic [$clog2(SHAPE_H)-1:0] y,
  output logic                       sof,
  output logic                       eol,
  output logic                       eof
);
  localparam int XW = $clog2(SHAPE_W);
  localparam int YW = $clog2(SHAPE_H);
  localparam logic [XW-1:0] X_LAST = XW'(SHAPE_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SHAPE_H - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  assign x   = x_q;
  assign y   = y_q;
  assign sof = (x_q == '0) && (y_q == '0);
  assign eol = (x_q == X_LAST);
  assign eof = eol && (y_q == Y_LAST);

  // clr wins: an early frame end restarts the raster at (0,0)
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (adv) begin
      if (eol) begin
        x_d = '0;
        y_d = eof ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
endmodule

// File: rtl/cam_pixel_unpacker.sv
// Splits camera bus words into single pixels with raster coordinates, markers
// and a frame_end vs. geometry consistency check.
module cam_pixel_unpacker #(
  parameter int BUS_WIDTH = cam_pkg::BUS_WIDTH,
  parameter int PIX_WIDTH = cam_pkg::PIX_WIDTH,
  parameter int SHAPE_W   = cam_pkg::SHAPE_W,
  parameter int SHAPE_H   = cam_pkg::SHAPE_H
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       cam_ready,
  input  logic                       cam_valid,
  input  logic [BUS_WIDTH-1:0]       cam_data,
  input  logic                       cam_frame_end,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [PIX_WIDTH-1:0]       pix_data,
  output logic [$clog2(SHAPE_W)-1:0] pix_x,
  output logic [$clog2(SHAPE_H)-1:0] pix_y,
  output logic                       pix_sof,
  output logic                       pix_eol,
  output logic                       pix_eof,
  output logic                       frame_err,
  output logic [15:0]                frame_cnt
);
  import cam_pkg::*;

  localparam int PPW = BUS_WIDTH / PIX_WIDTH;
  localparam int LW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(PPW - 1);

  cam_state_e           state_q, state_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic [BUS_WIDTH-1:0] buf_q, buf_d;
  logic                 fe_q, fe_d;
  logic                 err_q, err_d;
  logic [15:0]          cnt_q, cnt_d;

  logic last_lane, in_xfer, pix_xfer, word_end;
  logic early_end, late_end, frame_done;

  // The buffer shifts one pixel toward the MSBs per transfer, so the
  // current lane always sits in the top slice of a flop.
  assign pix_data  = buf_q[BUS_WIDTH-1 -: PIX_WIDTH];
  assign pix_valid = (state_q == DRAIN);
  assign frame_err = err_q;
  assign frame_cnt = cnt_q;

  always_comb begin
    last_lane  = (lane_q == LANE_LAST);
    cam_ready  = (state_q == EMPTY) | (last_lane & pix_ready);
    in_xfer    = cam_valid & cam_ready;
    pix_xfer   = pix_valid & pix_ready;
    word_end   = pix_xfer & last_lane;
    early_end  = word_end & fe_q & ~pix_eof;
    late_end   = word_end & ~fe_q & pix_eof;
    frame_done = word_end & fe_q & pix_eof;
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    buf_d   = buf_q;
    fe_d    = fe_q;
    err_d   = early_end | late_end;
    cnt_d   = cnt_q + 16'(frame_done);
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = DRAIN;
          lane_d  = '0;
          buf_d   = cam_data;
          fe_d    = cam_frame_end;
        end
      end
      DRAIN: begin
        if (pix_xfer) begin
          if (!last_lane) begin
            lane_d = lane_q + LW'(1);
            buf_d  = buf_q << PIX_WIDTH;
          end else if (in_xfer) begin
            // reload on the last lane keeps the output bubble-free
            lane_d = '0;
            buf_d  = cam_data;
            fe_d   = cam_frame_end;
          end else begin
            state_d = EMPTY;
            lane_d  = '0;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      lane_q  <= '0;
      buf_q   <= '0;
      fe_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      buf_q   <= buf_d;
      fe_q    <= fe_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  cam_pixel_coord #(
    .SHAPE_W (SHAPE_W),
    .SHAPE_H (SHAPE_H)
  ) u_coord (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (pix_xfer),
    .clr   (early_end),
    .x     (pix_x),
    .y     (pix_y),
    .sof   (pix_sof),
    .eol   (pix_eol),
    .eof   (pix_eof)
  );
endmodule

// File: tb/tb_cam_pixel_unpacker.sv
// Scoreboard bench for cam_pixel_unpacker on a reduced 16x3 frame geometry.
module tb_cam_pixel_unpacker;
  localparam int BW   = 96;
  localparam int PW   = 24;
  localparam int W    = 16;
  localparam int H    = 3;
  localparam int PPW  = BW / PW;
  localparam int XW   = $clog2(W);
  localparam int YW   = $clog2(H);
  localparam int NPIX = W * H;
  localparam int WPF  = NPIX / PPW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cam_ready, cam_valid = 1'b0, cam_frame_end = 1'b0;
  logic [BW-1:0] cam_data = '0;
  logic          pix_valid, pix_ready = 1'b1;
  logic [PW-1:0] pix_data;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_sof, pix_eol, pix_eof, frame_err;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  cam_pixel_unpacker #(
    .BUS_WIDTH (BW), .PIX_WIDTH (PW), .SHAPE_W (W), .SHAPE_H (H)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .cam_ready (cam_ready), .cam_valid (cam_valid), .cam_data (cam_data),
    .cam_frame_end (cam_frame_end),
    .pix_valid (pix_valid), .pix_ready (pix_ready), .pix_data (pix_data),
    .pix_x (pix_x), .pix_y (pix_y),
    .pix_sof (pix_sof), .pix_eol (pix_eol), .pix_eof (pix_eof),
    .frame_err (frame_err), .frame_cnt (frame_cnt)
  );

  typedef struct {
    logic [PW-1:0] d;
    int            x;
    int            y;
    bit            sof, eol, eof, err, inc;
  } exp_t;

  exp_t q[$];
  int   pos = 0;       // linear raster index of the next expected pixel
  int   exp_cnt = 0;
  bit   err_pend = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   bp_pct = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: raster position as a single index, frame_end rules applied per word.
  function automatic void model_push(input logic [BW-1:0] data, input bit fe);
    for (int l = 0; l < PPW; l++) begin
      exp_t e;
      e.d   = PW'(data >> ((PPW - 1 - l) * PW));
      e.x   = pos % W;
      e.y   = pos / W;
      e.sof = (pos == 0);
      e.eol = (e.x == W - 1);
      e.eof = (pos == NPIX - 1);
      e.err = 1'b0;
      e.inc = 1'b0;
      if (l == PPW - 1 && (fe || e.eof)) begin
        e.err = !(fe && e.eof);
        e.inc = fe && e.eof;
        pos   = 0;
      end else begin
        pos = (pos + 1) % NPIX;
      end
      q.push_back(e);
    end
  endfunction

  // Monitor: checks at the falling edge, transfers take effect at the next rising edge.
  always @(negedge clk) begin
    bit exp_rdy;
    if (!rst_n) begin
      q.delete();
      pos      = 0;
      exp_cnt  = 0;
      err_pend = 1'b0;
    end else begin
      exp_rdy = (q.size() == 0) || (q.size() == 1 && pix_ready);
      chk("pix_valid", 64'(pix_valid), 64'(q.size() != 0));
      chk("cam_ready", 64'(cam_ready), 64'(exp_rdy));
      chk("frame_err", 64'(frame_err), 64'(err_pend));
      chk("frame_cnt", 64'(frame_cnt), 64'(exp_cnt[15:0]));
      err_pend = 1'b0;
      if (pix_valid && q.size() != 0) begin
        chk("pix_data", 64'(pix_data), 64'(q[0].d));
        chk("pix_x",    64'(pix_x),    64'(q[0].x));
        chk("pix_y",    64'(pix_y),    64'(q[0].y));
        chk("pix_sof",  64'(pix_sof),  64'(q[0].sof));
        chk("pix_eol",  64'(pix_eol),  64'(q[0].eol));
        chk("pix_eof",  64'(pix_eof),  64'(q[0].eof));
        if (pix_ready) begin
          err_pend = q[0].err;
          if (q[0].inc) exp_cnt++;
          void'(q.pop_front());
        end
      end
      if (cam_valid && cam_ready) model_push(cam_data, cam_frame_end);
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      pix_ready = ($urandom_range(99) >= bp_pct);
    end
  end

  function automatic logic [BW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic send(input logic [BW-1:0] d, input bit fe, input int gap_pct);
    int t = 0;
    while (gap_pct != 0 && $urandom_range(99) < gap_pct) begin
      cam_valid = 1'b0;
      @(posedge clk); #1;
    end
    cam_valid     = 1'b1;
    cam_data      = d;
    cam_frame_end = fe;
    do begin
      @(negedge clk);
      t++;
    end while (!cam_ready && t < 2000);
    checks++;
    if (!cam_ready) begin
      errors++;
      $display("FAIL send_timeout: cam_ready stayed 0 for %0d cycles, required 1", t);
    end
    @(posedge clk); #1;
    cam_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d pixels outstanding, required 0", q.size());
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    cam_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_pix_valid", 64'(pix_valid), 64'(0));
    chk("rst_cam_ready", 64'(cam_ready), 64'(1));
    chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    chk("rst_frame_err", 64'(frame_err), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();
    bp_pct = 0;

    send(96'h111111_222222_333333_444444, 1'b0, 0);
    drain();

    do_reset();
    for (int w = 0; w < WPF; w++) send(rand_word(), w == WPF - 1, 0);
    drain();
    chk("frame_cnt_full", 64'(frame_cnt), 64'(1));

    bp_pct = 30;
    for (int f = 0; f < 3; f++)
      for (int w = 0; w < WPF; w++) send(rand_word(), w == WPF - 1, 20);
    drain();
    bp_pct = 0;
    chk("frame_cnt_bp", 64'(frame_cnt), 64'(4));

    for (int w = 0; w < 10; w++) send(rand_word(), w == 9, 0);
    for (int w = 0; w < WPF; w++) send(rand_word(), w == WPF - 1, 0);
    drain();
    chk("frame_cnt_early", 64'(frame_cnt), 64'(5));

    for (int w = 0; w < WPF; w++) send(rand_word(), 1'b0, 10);
    for (int w = 0; w < WPF; w++) send(rand_word(), w == WPF - 1, 0);
    drain();
    chk("frame_cnt_late", 64'(frame_cnt), 64'(6));

    send(rand_word(), 1'b0, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("midword_valid", 64'(pix_valid), 64'(1));
    do_reset();
    send(rand_word(), 1'b0, 0);
    send(rand_word(), 1'b0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cam_pixel_unpacker.md
Name: cam_pixel_unpacker

Overview:
- Sits directly downstream of the camera source.
- Accepts BUS_WIDTH-wide words through a ready/valid handshake and splits each word into PIX_PER_WORD pixels.
- Emits one pixel per transfer with x/y coordinates and start-of-frame, end-of-line and end-of-frame markers. This pixel stream feeds the copter-detection pipeline.
- Checks the source's frame_end marker against the configured frame geometry.

Parameters:
- BUS_WIDTH, 96: input word width in bits.
- PIX_WIDTH, 24: pixel width in bits (3 channels x 8 bits).
- SHAPE_W, 848: pixels per line. Must be a multiple of PIX_PER_WORD.
- SHAPE_H, 480: lines per frame.
- PIX_PER_WORD, derived local constant = BUS_WIDTH/PIX_WIDTH (4). BUS_WIDTH must be an exact multiple of PIX_WIDTH.

Ports:
- clk  in  1  system clock; all logic acts on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cam_ready  out  1  block can accept a word this cycle.
- cam_valid  in  1  cam_data is valid.
- cam_data  in  BUS_WIDTH  packed pixels; pixel 0 is at the MSBs.
- cam_frame_end  in  1  qualified by cam_valid; marks the word carrying the last pixel of a frame.
- pix_valid  out  1  output pixel is valid.
- pix_ready  in  1  downstream accepts the pixel.
- pix_data  out  PIX_WIDTH  pixel value.
- pix_x  out  clog2(SHAPE_W)  column of pix_data.
- pix_y  out  clog2(SHAPE_H)  row of pix_data.
- pix_sof  out  1  pixel is (0,0).
- pix_eol  out  1  pixel has x = SHAPE_W-1.
- pix_eof  out  1  pixel is (SHAPE_W-1, SHAPE_H-1).
- frame_err  out  1  one-cycle pulse on a geometry/frame_end mismatch.
- frame_cnt  out  16  count of completed frames.

Behaviour:
- Reset is asynchronous on rst_n low. All registers clear immediately:
  - state = EMPTY, lane = 0, x = y = 0;
  - frame_end flag = 0, frame_cnt = 0;
  - pix_valid = 0, frame_err = 0, pix_data = 0.
  - cam_ready is driven from state, so it is 1 during reset and after it.
- Reset asserted mid-word discards that word. Reset release is synchronous to clk only through the flops' normal recovery; no extra synchronizer is built into this block.
- Input handshake: a word is transferred when cam_valid & cam_ready at a rising edge. The word and cam_frame_end are latched into a one-word buffer.
- Output handshake: a pixel is transferred when pix_valid & pix_ready.
  - pix_data, pix_x, pix_y and all markers are registered.
  - They stay stable while pix_valid & ~pix_ready.
- State machine:
  - EMPTY: cam_ready = 1, pix_valid = 0. On an input transfer, go to DRAIN with lane = 0.
  - DRAIN: pix_valid = 1, and pix_data = buffer[BUS_WIDTH-1-lane*PIX_WIDTH -: PIX_WIDTH].
    - Pixel transfer with lane < PIX_PER_WORD-1: lane increments.
    - Pixel transfer with lane = PIX_PER_WORD-1 and cam_valid: load the next word, lane = 0, stay in DRAIN. This gives zero-bubble back-to-back operation.
    - Pixel transfer with lane = PIX_PER_WORD-1 and no cam_valid: go to EMPTY.
  - cam_ready = (state==EMPTY) | (lane==PIX_PER_WORD-1 & pix_ready). This is the only combinational input-to-output path.
- Latency: an input transfer at edge N makes the first pixel visible after edge N, so pix_valid is high in cycle N+1.
- Throughput: one pixel per clock while pix_ready stays high.
- Coordinates advance on each pixel transfer.
  - x increments; at x = SHAPE_W-1, x wraps to 0 and y increments.
  - At (SHAPE_W-1, SHAPE_H-1), both wrap to 0.
- Markers are decoded from the current x/y.
- frame_end check, applied on transfer of the last lane of a word:
  - Latched frame_end = 1 and pixel is eof: normal completion. frame_cnt increments, wrapping at 16 bits.
  - Latched frame_end = 1 and pixel is not eof (early end): frame_err pulses for one cycle, and x and y are forced to 0 so the next pixel carries sof. frame_cnt does not increment.
  - Pixel is eof and latched frame_end = 0 (late end): frame_err pulses for one cycle, and the counters wrap normally. frame_cnt does not increment.
- frame_err is registered and high for exactly one cycle after the offending transfer.
- Back-pressure never drops or duplicates data. A cam_valid presented while cam_ready = 0 is not consumed.

Decomposition:
- Shared package (cam_pkg) holds:
  - BUS_WIDTH, PIX_WIDTH, SHAPE_W and SHAPE_H defaults;
  - derived PIX_PER_WORD, X_W and Y_W;
  - the state encoding (EMPTY, DRAIN).
- One sub-module, cam_pixel_coord: x/y counters plus sof/eol/eof decode. Its inputs are an advance strobe and a force-zero strobe.

Test Plan:
- Reset: hold rst_n low, then release. Expect cam_ready = 1, pix_valid = 0, frame_cnt = 0, and no frame_err.
- Single word 0x111111_222222_333333_444444 with pix_ready high: expect pixels 0x111111, 0x222222, 0x333333, 0x444444 at x = 0..3, y = 0, sof on the first only, then return to EMPTY.
- Full frame, streamed back-to-back with frame_end on word 101760 (212x480): expect 407040 pixels with no bubbles, eol at every x = 847, one eof at (847,479), frame_cnt = 1 and no frame_err.
- Random pix_ready back-pressure at 30% over 3 frames: expect the output sequence identical to the input order, and data held stable while stalled.
- frame_end on word 10 (early): expect frame_err pulse after pixel (39,0), the next pixel at (0,0) with sof, and frame_cnt unchanged.
- Frame with frame_end withheld (late): expect eof at (847,479), frame_err pulse, and frame_cnt unchanged.
- rst_n pulsed low during lane 2 of a word: expect immediate pix_valid = 0, and the next accepted word starts at (0,0).
